// File: rtl/un_minus_check.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | un_minus_check : walks 25 negation-result fields of a latched vector pair |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module un_minus_check #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     vec_in,
  input  logic [127:0]     vec_out,
  output logic             res_valid,
  output logic             res_pass,
  output logic [4:0]       res_nerr,
  output logic [4:0]       res_first,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [4:0] C_NONE    = 5'd31;
  localparam logic [4:0] C_LAST_K  = 5'd24;

  state_t       state_q;
  logic [89:0]  vin_q;
  logic [127:0] vout_q;
  logic [4:0]   k_q;
  logic [4:0]   nerr_q;
  logic [4:0]   first_q;

  logic         unused_hi;
  assign unused_hi = ^vec_in[127:90];

  logic [8:0] a9, b9;
  logic [7:0] a8, b8;
  logic [6:0] a7, b7;
  logic [5:0] a6, b6;
  logic [4:0] a5, b5;
  logic [3:0] a4, b4;
  logic [2:0] a3, b3;
  logic [1:0] a2, b2;
  logic       a1, b1;

  assign a9 = vin_q[89:81];
  assign a8 = vin_q[80:73];
  assign a7 = vin_q[72:66];
  assign a6 = vin_q[65:60];
  assign a5 = vin_q[59:55];
  assign a4 = vin_q[54:51];
  assign a3 = vin_q[50:48];
  assign a2 = vin_q[47:46];
  assign a1 = vin_q[45];
  assign b9 = vin_q[44:36];
  assign b8 = vin_q[35:28];
  assign b7 = vin_q[27:21];
  assign b6 = vin_q[20:15];
  assign b5 = vin_q[14:10];
  assign b4 = vin_q[9:6];
  assign b3 = vin_q[5:3];
  assign b2 = vin_q[2:1];
  assign b1 = vin_q[0];

  function automatic logic [8:0] neg9(input logic [8:0] x, input logic [8:0] m);
    return (9'd0 - x) & m;
  endfunction

  logic [8:0] fld_exp;
  logic [8:0] fld_act;
  logic       mismatch;
  logic [4:0] nerr_next;
  logic [4:0] first_next;

  // Fields are zero-extended to 9 bits; expected value is the field-width negation.
  always_comb begin
    fld_exp = '0;
    fld_act = '0;
    case (k_q)
      5'd0:  begin fld_exp = neg9({8'b0, a1}, 9'h001); fld_act = {8'b0, vout_q[0]};       end
      5'd1:  begin fld_exp = neg9({7'b0, a2}, 9'h003); fld_act = {7'b0, vout_q[2:1]};     end
      5'd2:  begin fld_exp = neg9({6'b0, a3}, 9'h007); fld_act = {6'b0, vout_q[5:3]};     end
      5'd3:  begin fld_exp = neg9({5'b0, a4}, 9'h00F); fld_act = {5'b0, vout_q[9:6]};     end
      5'd4:  begin fld_exp = neg9({4'b0, a5}, 9'h01F); fld_act = {4'b0, vout_q[14:10]};   end
      5'd5:  begin fld_exp = neg9({3'b0, a6}, 9'h03F); fld_act = {3'b0, vout_q[20:15]};   end
      5'd6:  begin fld_exp = neg9({2'b0, a7}, 9'h07F); fld_act = {2'b0, vout_q[27:21]};   end
      5'd7:  begin fld_exp = neg9({1'b0, a8}, 9'h0FF); fld_act = {1'b0, vout_q[35:28]};   end
      5'd8:  begin fld_exp = neg9(a9, 9'h1FF);         fld_act = vout_q[44:36];           end
      5'd9:  begin fld_exp = neg9({8'b0, b1}, 9'h001); fld_act = {8'b0, vout_q[45]};      end
      5'd10: begin fld_exp = neg9({7'b0, b2}, 9'h003); fld_act = {7'b0, vout_q[47:46]};   end
      5'd11: begin fld_exp = neg9({6'b0, b3}, 9'h007); fld_act = {6'b0, vout_q[50:48]};   end
      5'd12: begin fld_exp = neg9({5'b0, b4}, 9'h00F); fld_act = {5'b0, vout_q[54:51]};   end
      5'd13: begin fld_exp = neg9({4'b0, b5}, 9'h01F); fld_act = {4'b0, vout_q[59:55]};   end
      5'd14: begin fld_exp = neg9({3'b0, b6}, 9'h03F); fld_act = {3'b0, vout_q[65:60]};   end
      5'd15: begin fld_exp = neg9({2'b0, b7}, 9'h07F); fld_act = {2'b0, vout_q[72:66]};   end
      5'd16: begin fld_exp = neg9({1'b0, b8}, 9'h0FF); fld_act = {1'b0, vout_q[80:73]};   end
      5'd17: begin fld_exp = neg9(b9, 9'h1FF);         fld_act = vout_q[89:81];           end
      5'd18: begin fld_exp = neg9(a9, 9'h03F);         fld_act = {3'b0, vout_q[95:90]};   end
      5'd19: begin fld_exp = neg9(a9, 9'h03F);         fld_act = {3'b0, vout_q[101:96]};  end
      5'd20: begin fld_exp = neg9({6'b0, a3}, 9'h03F); fld_act = {3'b0, vout_q[107:102]}; end
      5'd21: begin fld_exp = neg9({3'b0, {3{b3[2]}}, b3}, 9'h03F); fld_act = {3'b0, vout_q[113:108]}; end
      5'd22: begin fld_exp = neg9({8'b0, a1}, 9'h03F); fld_act = {3'b0, vout_q[119:114]}; end
      5'd23: begin fld_exp = neg9({3'b0, {6{b1}}}, 9'h03F); fld_act = {3'b0, vout_q[125:120]}; end
      5'd24: begin fld_exp = 9'd0;                     fld_act = {7'b0, vout_q[127:126]}; end
      default: begin fld_exp = 9'd0;                   fld_act = 9'd0;                    end
    endcase
  end

  // Case inequality so that X/Z in the captured result counts as a mismatch.
  assign mismatch   = (fld_act !== fld_exp);
  assign nerr_next  = nerr_q + {4'b0, mismatch};
  assign first_next = (mismatch && (first_q == C_NONE)) ? k_q : first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      res_nerr  <= 5'd0;
      res_first <= C_NONE;
      vec_count <= '0;
      err_count <= '0;
      vin_q     <= '0;
      vout_q    <= '0;
      k_q       <= 5'd0;
      nerr_q    <= 5'd0;
      first_q   <= C_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            vin_q    <= vec_in[89:0];
            vout_q   <= vec_out;
            nerr_q   <= 5'd0;
            first_q  <= C_NONE;
            k_q      <= 5'd0;
            in_ready <= 1'b0;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (k_q == C_LAST_K) begin
            res_valid <= 1'b1;
            res_nerr  <= nerr_next;
            res_first <= first_next;
            res_pass  <= (nerr_next == 5'd0);
            if (vec_count != '1) vec_count <= vec_count + CNT_W'(1);
            if ((nerr_next != 5'd0) && (err_count != '1)) err_count <= err_count + CNT_W'(1);
            state_q   <= S_REPORT;
          end else begin
            nerr_q  <= nerr_next;
            first_q <= first_next;
            k_q     <= k_q + 5'd1;
          end
        end
        S_REPORT: begin
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_un_minus_check.sv
`default_nettype none
// Directed bench for un_minus_check: hand-computed vectors, reset abort, saturation.
module tb_un_minus_check;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_valid_s = 1'b0;
  logic [127:0] vec_in = '0;
  logic [127:0] vec_out = '0;

  logic         in_ready, res_valid, res_pass;
  logic [4:0]   res_nerr, res_first;
  logic [15:0]  vec_count, err_count;

  logic         in_ready_s, res_valid_s, res_pass_s;
  logic [4:0]   res_nerr_s, res_first_s;
  logic [1:0]   vec_count_s, err_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  un_minus_check #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .vec_in(vec_in), .vec_out(vec_out), .res_valid(res_valid), .res_pass(res_pass),
    .res_nerr(res_nerr), .res_first(res_first), .vec_count(vec_count), .err_count(err_count)
  );

  un_minus_check #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .vec_in(vec_in), .vec_out(vec_out), .res_valid(res_valid_s), .res_pass(res_pass_s),
    .res_nerr(res_nerr_s), .res_first(res_first_s), .vec_count(vec_count_s), .err_count(err_count_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [127:0] vi, input logic [127:0] vo,
                         input logic ep, input logic [4:0] en, input logic [4:0] ef,
                         input int evc, input int eec);
    int n;
    in_valid = 1'b1;
    vec_in   = vi;
    vec_out  = vo;
    step();
    chk({tag, ".busy"}, in_ready, 0);
    in_valid = 1'b0;
    vec_in   = ~vi;
    vec_out  = ~vo;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".lat"}, n, 25);
    chk({tag, ".pass"}, res_pass, ep);
    chk({tag, ".nerr"}, res_nerr, en);
    chk({tag, ".first"}, res_first, ef);
    chk({tag, ".vcnt"}, vec_count, evc);
    chk({tag, ".ecnt"}, err_count, eec);
    step();
    chk({tag, ".vdrop"}, res_valid, 0);
    chk({tag, ".ready"}, in_ready, 1);
    chk({tag, ".hold"}, res_nerr, en);
  endtask

  initial begin
    int pulses;
    step();
    step();
    chk("rst.ready", in_ready, 1);
    chk("rst.valid", res_valid, 0);
    chk("rst.pass", res_pass, 0);
    chk("rst.nerr", res_nerr, 0);
    chk("rst.first", res_first, 31);
    chk("rst.vcnt", vec_count, 0);
    chk("rst.ecnt", err_count, 0);
    rst = 1'b0;
    step();
    chk("idle.ready", in_ready, 1);

    // Abort a check part-way through; reset also coincides with in_valid.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("abort.busy", in_ready, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("abort.ready", in_ready, 1);
    chk("abort.valid", res_valid, 0);
    chk("abort.vcnt", vec_count, 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (res_valid === 1'b1) pulses++;
    end
    chk("abort.pulses", pulses, 0);
    chk("abort.vcnt2", vec_count, 0);
    chk("abort.ready2", in_ready, 1);

    run_vec("zero", '0, '0, 1'b1, 5'd0, 5'd31, 1, 0);
    run_vec("a1ok", 128'd1 << 45, (128'd1 << 0) | (128'h3F << 114), 1'b1, 5'd0, 5'd31, 2, 0);
    run_vec("a1bad", 128'd1 << 45, '0, 1'b0, 5'd2, 5'd0, 3, 1);
    run_vec("b3ok", 128'd4 << 3, (128'd4 << 48) | (128'h04 << 108), 1'b1, 5'd0, 5'd31, 4, 1);
    run_vec("a9ok", 128'd1 << 81, (128'h1FF << 36) | (128'h3F << 90) | (128'h3F << 96),
            1'b1, 5'd0, 5'd31, 5, 1);
    run_vec("a9pad", 128'd1 << 81,
            (128'h1FF << 36) | (128'h3F << 90) | (128'h3F << 96) | (128'd1 << 127),
            1'b0, 5'd1, 5'd24, 6, 2);
    run_vec("b1a3", (128'd1 << 0) | (128'd3 << 48),
            (128'd1 << 45) | (128'd5 << 3) | (128'h3D << 102) | (128'h01 << 120),
            1'b1, 5'd0, 5'd31, 7, 2);

    // in_valid held high: one acceptance per 27 cycles.
    vec_in   = '0;
    vec_out  = '0;
    in_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 81; i++) begin
      step();
      if (res_valid === 1'b1) pulses++;
    end
    in_valid = 1'b0;
    chk("hold.pulses", pulses, 3);
    chk("hold.vcnt", vec_count, 10);
    chk("hold.ecnt", err_count, 2);

    // Narrow counters: five failing vectors saturate both counts at 3.
    vec_out    = 128'd1;
    in_valid_s = 1'b1;
    pulses = 0;
    for (int i = 0; i < 135; i++) begin
      step();
      if (res_valid_s === 1'b1) pulses++;
    end
    in_valid_s = 1'b0;
    chk("sat.pulses", pulses, 5);
    chk("sat.vcnt", vec_count_s, 3);
    chk("sat.ecnt", err_count_s, 3);
    chk("sat.pass", res_pass_s, 0);
    chk("sat.nerr", res_nerr_s, 1);
    chk("sat.first", res_first_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
